// File: rtl/tt_um_fa_exerciser.sv
// ============================================================================
// Module   : tt_um_fa_exerciser
// Purpose  : On-chip stimulus/checker that walks a full adder through all 8
//            input vectors and counts mismatches against a golden model.
//            Optional build macro: FA_EXERCISER_FAULT_INJECT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_um_fa_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic       sync1, sync2, start_prev;
    logic [2:0] idx, idx_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] err_cnt, err_nx;
    logic       fail, fail_nx;

    logic       start_rise;
    logic       start_go;
    logic       exp_sum, exp_cout;
    logic       mismatch;
    logic       busy, done, pass;

    assign start_rise = sync2 & ~start_prev;
    assign start_go   = start_rise & ((state == ST_IDLE) | (state == ST_DONE));

    // {a,b,cin} = idx, so a is idx[2] and cin is idx[0]
    assign exp_cout = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);

`ifdef FA_EXERCISER_FAULT_INJECT_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (ena && start_go) begin
            fault_q <= ui_in[2];
        end
    end

    assign exp_sum = (^idx) ^ (fault_q & (idx == 3'd5));
`else
    assign exp_sum = ^idx;
`endif

    assign mismatch = ({uio_in[4], uio_in[3]} != {exp_cout, exp_sum});

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        err_nx   = err_cnt;
        fail_nx  = fail;
        case (state)
            ST_IDLE: begin
                if (start_go) begin
                    state_nx = ST_DRIVE;
                    idx_nx   = 3'd0;
                    err_nx   = 4'd0;
                    fail_nx  = 1'b0;
                end
            end
            ST_DRIVE: begin
                cnt_nx   = SETTLE_LOAD;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_CHECK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_nx = 1'b1;
                    if (err_cnt != 4'hF) begin
                        err_nx = err_cnt + 4'd1;
                    end
                end
                if (idx == 3'd7) begin
                    state_nx = ST_DONE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    state_nx = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // A fresh edge restarts with cleared results; a loop restart keeps them
                if (start_go) begin
                    state_nx = ST_DRIVE;
                    idx_nx   = 3'd0;
                    err_nx   = 4'd0;
                    fail_nx  = 1'b0;
                end else if (ui_in[1] && sync2) begin
                    state_nx = ST_DRIVE;
                    idx_nx   = 3'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            start_prev <= 1'b0;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            err_cnt    <= 4'd0;
            fail       <= 1'b0;
        end else if (ena) begin
            state      <= state_nx;
            sync1      <= ui_in[0];
            sync2      <= sync1;
            start_prev <= sync2;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            err_cnt    <= err_nx;
            fail       <= fail_nx;
        end
    end

    assign busy = (state == ST_DRIVE) | (state == ST_WAIT) | (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done & (err_cnt == 4'd0);

    assign uo_out  = {err_cnt, fail, pass, done, busy};
    assign uio_out = (state == ST_IDLE) ? 8'h00 : {5'b0, idx[0], idx[1], idx[2]};
    assign uio_oe  = 8'b0000_0111;

    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in[7:2], uio_in[7:5], uio_in[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_fa_exerciser.sv
// ============================================================================
// Module   : tb_tt_um_fa_exerciser
// Purpose  : Directed self-checking bench for tt_um_fa_exerciser with a
//            behavioural full adder that can be given stuck/swap faults.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_fa_exerciser;

    localparam int SETTLE   = 2;
    localparam int PER_VEC  = 2 + SETTLE;
    localparam int RUN_LEN  = 8 * PER_VEC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    tt_um_fa_exerciser #(.SETTLE_CYCLES(SETTLE)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 good, 1 sum stuck-0, 2 cout stuck-1, 3 sum/cout swapped, 4 sum inverted
    logic ma, mb, mc, m_s, m_c;
    always_comb begin
        ma  = uio_out[0];
        mb  = uio_out[1];
        mc  = uio_out[2];
        m_s = ma ^ mb ^ mc;
        m_c = (ma & mb) | (ma & mc) | (mb & mc);
        uio_in = {3'b110, m_c, m_s, 3'b101};
        case (mode)
            1: uio_in[3] = 1'b0;
            2: uio_in[4] = 1'b1;
            3: uio_in[4:3] = {m_s, m_c};
            4: uio_in[3] = ~m_s;
            default: ;
        endcase
    end

    typedef struct {
        int         mode;
        logic       fault;
        logic [7:0] exp_uo;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] rev3(input int i);
        logic [2:0] v;
        v = i[2:0];
        return {v[0], v[1], v[2]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        ena   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uo_out", {24'b0, uo_out}, 32'h00);
        chk("reset_uio_out", {24'b0, uio_out}, 32'h00);
        chk("reset_uio_oe", {24'b0, uio_oe}, 32'h07);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // One start-pulsed run; optionally freezes ena for 10 cycles at idx=2 DRIVE
    task automatic run(input int mode_i, input logic fault_i, input bit drop,
                       input logic [7:0] exp_uo, input int exp_len);
        int  len, k, freeze;
        bit  walk_ok, dropped;
        @(negedge clk);
        mode  = mode_i;
        ui_in = {5'b0, fault_i, 1'b0, 1'b1};
        @(posedge clk); #1;
        chk("latency_edge_n", {31'b0, uo_out[0]}, 32'd0);
        @(posedge clk); #1;
        chk("latency_edge_n1", {31'b0, uo_out[0]}, 32'd0);
        @(posedge clk); #1;
        chk("latency_edge_n2", {31'b0, uo_out[0]}, 32'd1);
        len = 0; k = 0; freeze = 0; walk_ok = 1'b1; dropped = 1'b0;
        while (uo_out[1] == 1'b0 && k < 400) begin
            if (uo_out[0]) begin
                len++;
                if (!drop && uio_out[2:0] != rev3((len - 1) / PER_VEC)) walk_ok = 1'b0;
            end
            if (drop && !dropped && uio_out[2:0] == 3'b010) begin
                ena = 1'b0;
                dropped = 1'b1;
                freeze = 10;
            end else if (freeze > 0) begin
                freeze--;
                if (freeze == 0) begin
                    chk("ena_hold_vec", {29'b0, uio_out[2:0]}, 32'h2);
                    ena = 1'b1;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        chk("run_timeout", {31'b0, uo_out[1]}, 32'd1);
        chk("run_length", len, exp_len);
        if (!drop) chk("vector_walk", {31'b0, walk_ok}, 32'd1);
        chk("run_uo_out", {24'b0, uo_out}, {24'b0, exp_uo});
        @(negedge clk);
        ena   = 1'b1;
        ui_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("done_holds", {24'b0, uo_out}, {24'b0, exp_uo});
    endtask

    task automatic wait_done(output bit ok);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (uo_out[1] == 1'b0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        ok = uo_out[1];
    endtask

    initial begin
        bit ok;
        int k;

        tbl[0] = '{0, 1'b0, 8'h06};
        tbl[1] = '{1, 1'b0, 8'h4A};
        tbl[2] = '{2, 1'b0, 8'h4A};
        tbl[3] = '{3, 1'b0, 8'h6A};
        tbl[4] = '{4, 1'b0, 8'h8A};
`ifdef FA_EXERCISER_FAULT_INJECT_EN
        tbl[5] = '{0, 1'b1, 8'h1A};
        tbl[6] = '{1, 1'b1, 8'h5A};
`else
        tbl[5] = '{0, 1'b1, 8'h06};
        tbl[6] = '{1, 1'b1, 8'h4A};
`endif

        do_reset();
        for (int i = 0; i < 7; i++) begin
            run(tbl[i].mode, tbl[i].fault, 1'b0, tbl[i].exp_uo, RUN_LEN);
        end

        // ena dropped mid idx=2: run stretches by exactly 10 cycles
        run(0, 1'b0, 1'b1, 8'h06, RUN_LEN + 10);
        run(1, 1'b0, 1'b1, 8'h4A, RUN_LEN + 10);

        // Asynchronous reset during WAIT of idx=3
        do_reset();
        @(negedge clk);
        mode  = 0;
        ui_in = 8'h01;
        k = 0;
        @(posedge clk); #1;
        while (!(uo_out[0] && uio_out[2:0] == 3'b110) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_idx3", {29'b0, uio_out[2:0]}, 32'h6);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", {24'b0, uo_out}, 32'h00);
        chk("async_rst_uio_out", {24'b0, uio_out}, 32'h00);
        chk("async_rst_uio_oe", {24'b0, uio_oe}, 32'h07);
        ui_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run(0, 1'b0, 1'b0, 8'h06, RUN_LEN);

        // Loop mode, cout stuck-at-1: 4 errors per pass, saturating at 15
        do_reset();
        @(negedge clk);
        mode  = 2;
        ui_in = 8'h03;
        for (int r = 1; r <= 4; r++) begin
            wait_done(ok);
            chk("loop_done_reached", {31'b0, ok}, 32'd1);
            chk("loop_err_cnt", {28'b0, uo_out[7:4]}, (r == 4) ? 32'd15 : 32'(4 * r));
            if (r < 4) begin
                @(posedge clk); #1;
                chk("loop_restart_1cycle", {30'b0, uo_out[1:0]}, 32'b01);
            end
        end
        ui_in = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("loop_hold_uo_out", {24'b0, uo_out}, 32'hFA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/tt_um_fa_exerciser.md
# tt_um_fa_exerciser

Built-in stimulus/checker for the full-adder tile: it drives the adder's three inputs, waits for settling, samples sum/carry back, and compares them against a golden model. It performs the driving and observing that the simulation bench does for the adder, but on silicon, over the standard Tiny Tapeout user-project pins. The adder under test connects through the bidirectional pins.

## Interface
- `SETTLE_CYCLES`, default 2, number of wait cycles between driving a vector and sampling it (range 1–15).
- `clk` input 1: single clock; all state is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: high when the design is selected; low freezes all state.
- `ui_in` input 8:
  - [0] start
  - [1] loop (rerun continuously while start stays high)
  - [2] fault-inject request (see Configuration)
  - [7:3] unused
- `uio_in` input 8:
  - [3] sum from the adder under test
  - [4] cout from the adder under test
  - other bits ignored
- `uio_out` output 8:
  - [0] a
  - [1] b
  - [2] cin
  - [7:3] = 0
- `uio_oe` output 8: constant 8'b0000_0111.
- `uo_out` output 8:
  - [0] busy
  - [1] done
  - [2] pass
  - [3] fail
  - [7:4] err_cnt

## Operation
- **Start detection:** `ui_in[0]` passes through a 2-flop synchronizer. A rising edge of the synchronized value, seen in IDLE or DONE, starts a run.
- **Vectors:** the vector index is `idx[2:0]`, counting 0..7, with {a,b,cin} = idx.
- **Golden model:**
  - exp_sum = a^b^cin
  - exp_cout = majority(a,b,cin)
- **FSM states:**
  - IDLE → DRIVE on start.
  - DRIVE (1 cycle): present the vector on `uio_out[2:0]`. → WAIT.
  - WAIT (SETTLE_CYCLES cycles): counter counts down. → CHECK.
  - CHECK (1 cycle): compare {`uio_in[4]`,`uio_in[3]`} with the expected value. A mismatch adds one error per vector (not per bit).
    - idx<7: idx++, → DRIVE.
    - idx=7: → DONE.
  - DONE: with loop=1 and synchronized start still high, clear idx and → DRIVE. Error count is not cleared. Otherwise hold until the next start edge.
- **Status outputs:**
  - busy = state ∈ {DRIVE, WAIT, CHECK}.
  - done = state==DONE.
- **Error count:** `err_cnt` is 4-bit and saturates at 15. It is cleared on each new start edge, but not on a loop restart.
- **Pass/fail:**
  - pass = done & (err_cnt==0).
  - fail: sticky, set on the first mismatch, cleared only by a start edge or reset.
- **Vector hold:** `uio_out[2:0]` keeps the current vector through WAIT and CHECK. It is 0 in IDLE and keeps the last vector in DONE.
- **Start edge during a run:** ignored while busy.
- **`ena`=0:** holds all registers, including the synchronizer and counters. Outputs are unchanged. Operation resumes where it stopped.

## Timing
- **Reset values:**
  - `uo_out` = 0.
  - `uio_out` = 0.
  - `uio_oe` = 8'h07 (constant, also during reset).
  - FSM in IDLE; idx, err_cnt and fail cleared.
- **Reset mid-run:** `rst_n` low forces the reset values asynchronously, whatever the state.
- **Start latency:** `ui_in[0]` high before clk edge N gives state DRIVE (busy=1) after edge N+2.
- **Per vector:** 2+SETTLE_CYCLES cycles.
- **Per run:** 8·(2+SETTLE_CYCLES) cycles; 32 cycles at the default.
- **Sampling point:** `uio_in` is sampled on the clock edge that leaves CHECK. The adder's response must be stable for SETTLE_CYCLES+1 cycles after DRIVE.
- **Loop restart:** DONE lasts exactly 1 cycle before DRIVE.
- **Last-vector error:** a mismatch on vector 7 is reflected in err_cnt and fail on the same edge that enters DONE, so pass is never transiently 1.

## Configuration
- **`FA_EXERCISER_FAULT_INJECT_EN` defined:**
  - When `ui_in[2]`=1 at the start edge, exp_sum for idx=5 is inverted for the whole run, loop restarts included.
  - A good adder then yields exactly 1 error per pass.
  - The request is latched at the start edge.
- **Not defined:** `ui_in[2]` is ignored, no fault logic is synthesized, and behaviour is identical to defined-with-`ui_in[2]`=0.

## Test plan
- **Correct adder, default settle:** loop the bench's correct adder back, pulse start → busy for 32 cycles, idx walks 0..7 → done=1, pass=1, fail=0, err_cnt=0, `uo_out`=8'h06.
- **Sum stuck-at-0:** same stimulus with sum held 0 → errors on idx 1,2,4,7 → err_cnt=4, fail=1, pass=0, `uo_out`=8'h4A.
- **Reset mid-run:** assert `rst_n`=0 at idx=3 during WAIT → `uo_out`=0 and `uio_out`=0 immediately, `uio_oe`=8'h07. After release, a new start completes a full, clean run.
- **`ena` low:** drop `ena` for 10 cycles in the middle of idx=2 → run length grows by exactly 10 cycles; results are identical to the uninterrupted run.
- **Loop mode with cout stuck-at-1:** loop=1, start held high for 3 runs → err_cnt = 4, 8, 12 at successive DONE cycles. In the 4th run it saturates at 15 after 3 more errors and stays 15.
- **Fault injection:** with `FA_EXERCISER_FAULT_INJECT_EN` defined and `ui_in[2]`=1, correct adder → err_cnt=1, fail=1. With the macro undefined, the same stimulus gives err_cnt=0 and pass=1.
